gf_mult_seq: RTL and testbench

//   Parametrised sequential GF(2^WIDTH) multiplier using shift-and-add with polynomial reduction.

---
 rtl/gf_pkg.sv | 27 ++
 rtl/gf_mult_step.sv | 25 ++
 rtl/gf_mult_seq.sv | 110 +++++++++++
 tb/tb_gf_mult_seq.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared GF(2^m) definitions: AES polynomial, multiplier FSM states,
// and a width-generic xtime (multiply-by-x with reduction) helper.
package gf_pkg;

  localparam logic [8:0] AES_POLY_8 = 9'h11B;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } gf_mult_state_t;

  // Multiply a by x modulo poly in GF(2^width), width in 2..32.
  // poly carries only the low width bits (the x^width term is implied).
  function automatic logic [31:0] gf_xtime(
    input logic [31:0] a,
    input logic [31:0] poly,
    input int unsigned width
  );
    logic [31:0] mask;
    logic [31:0] sh;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    sh   = (a << 1) & mask;
    return a[width-1] ? (sh ^ (poly & mask)) : sh;
  endfunction

endpackage

// File: rtl/gf_mult_step.sv
// One shift-and-add iteration of the GF multiplier (combinational).
// Ports: a_r_i/b_r_i/acc_i current state; a_r_o/b_r_o/acc_o next state.
module gf_mult_step
  import gf_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH:0]   POLY  = AES_POLY_8
) (
  input  logic [WIDTH-1:0] a_r_i,
  input  logic [WIDTH-1:0] b_r_i,
  input  logic [WIDTH-1:0] acc_i,
  output logic [WIDTH-1:0] a_r_o,
  output logic [WIDTH-1:0] b_r_o,
  output logic [WIDTH-1:0] acc_o
);

  always_comb begin
    acc_o = acc_i ^ (b_r_i[0] ? a_r_i : '0);
    a_r_o = WIDTH'(gf_xtime(32'(a_r_i),
                            32'(POLY[WIDTH-1:0]),
                            WIDTH));
    b_r_o = b_r_i >> 1;
  end

endmodule

// File: rtl/gf_mult_seq.sv
// Sequential GF(2^WIDTH) multiplier, one multiplier bit per clock.
// Ports: clk, reset (sync, high); in_valid/in_ready/a/b operand side;
// out_valid/out_ready/prod result side; busy high while iterating.
module gf_mult_seq
  import gf_pkg::*;
#(
  parameter int unsigned    WIDTH      = 8,
  parameter logic [WIDTH:0] POLY       = AES_POLY_8,
  parameter bit             EARLY_DONE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] prod,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  gf_mult_state_t   state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] prod_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] acc_d;
  logic             last;

  gf_mult_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .a_r_i (a_q),
    .b_r_i (b_q),
    .acc_i (acc_q),
    .a_r_o (a_d),
    .b_r_o (b_d),
    .acc_o (acc_d)
  );

  // cnt_q is the pre-increment count: the WIDTH-th iteration has
  // cnt_q == WIDTH-1. Early exit once no multiplier bits remain.
  assign last = (cnt_q == CW'(WIDTH - 1)) ||
                (EARLY_DONE && (b_d == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      prod_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_d;
          b_q   <= b_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            prod_q      <= acc_d;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign prod      = prod_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gf_mult_seq.sv
// Directed bench for gf_mult_seq: two 8-bit instances (EARLY_DONE 0/1)
// and one GF(2^4) instance with a reference model.
module tb_gf_mult_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [1:0] iv = '0;
  logic [1:0] ird;
  logic [1:0] ov;
  logic [1:0] ordy = '0;
  logic [1:0] bsy;
  logic [7:0] a8 [2];
  logic [7:0] b8 [2];
  logic [7:0] p8 [2];

  logic       iv4 = 1'b0;
  logic       ird4;
  logic       ov4;
  logic       ordy4 = 1'b0;
  logic       bsy4;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic [3:0] p4;

  gf_mult_seq #(.WIDTH(8), .POLY(9'h11B), .EARLY_DONE(1'b0)) u8 (
    .clk(clk), .reset(reset),
    .in_valid(iv[0]), .in_ready(ird[0]),
    .a(a8[0]), .b(b8[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .prod(p8[0]), .busy(bsy[0])
  );

  gf_mult_seq #(.WIDTH(8), .POLY(9'h11B), .EARLY_DONE(1'b1)) u8e (
    .clk(clk), .reset(reset),
    .in_valid(iv[1]), .in_ready(ird[1]),
    .a(a8[1]), .b(b8[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .prod(p8[1]), .busy(bsy[1])
  );

  gf_mult_seq #(.WIDTH(4), .POLY(5'h13), .EARLY_DONE(1'b0)) u4 (
    .clk(clk), .reset(reset),
    .in_valid(iv4), .in_ready(ird4),
    .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(ordy4),
    .prod(p4), .busy(bsy4)
  );

  // Carry-less product followed by long division by x^4+x+1.
  function automatic logic [3:0] ref4(input logic [3:0] x,
                                      input logic [3:0] y);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      if (y[i]) p = p ^ (7'(x) << i);
    for (int i = 6; i >= 4; i--)
      if (p[i]) p = p ^ (7'(5'h13) << (i - 4));
    return p[3:0];
  endfunction

  task automatic start8(input int s, input logic [7:0] a,
                        input logic [7:0] b);
    @(negedge clk);
    iv[s] = 1'b1; a8[s] = a; b8[s] = b;
    @(posedge clk); #1;
    iv[s] = 1'b0; a8[s] = ~a; b8[s] = ~b;
  endtask

  task automatic wait8(input int s, output int lat, output bit tmo);
    lat = 0; tmo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (ov[s]) begin tmo = 1'b0; break; end
    end
  endtask

  task automatic ack8(input int s);
    ordy[s] = 1'b1;
    @(posedge clk); #1;
    ordy[s] = 1'b0;
  endtask

  task automatic op8(input int s, input logic [7:0] a,
                     input logic [7:0] b, output logic [7:0] p,
                     output int lat, output bit tmo);
    start8(s, a, b);
    wait8(s, lat, tmo);
    p = p8[s];
    if (!tmo) ack8(s);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b,
                     output logic [3:0] p, output bit tmo);
    @(negedge clk);
    iv4 = 1'b1; a4 = a; b4 = b;
    @(posedge clk); #1;
    iv4 = 1'b0; a4 = ~a; b4 = ~b;
    tmo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ov4) begin tmo = 1'b0; break; end
    end
    p = p4;
    if (!tmo) begin
      ordy4 = 1'b1;
      @(posedge clk); #1;
      ordy4 = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      total++;
      if ({ird[s], ov[s], bsy[s], p8[s]} !== {3'b100, 8'h00}) begin
        bad++;
        $display("FAIL reset8[%0d]: got rdy/vld/busy/prod=%b%b%b/%h want 100/00",
                 s, ird[s], ov[s], bsy[s], p8[s]);
      end
    end
    total++;
    if ({ird4, ov4, bsy4, p4} !== {3'b100, 4'h0}) begin
      bad++;
      $display("FAIL reset4: got %b%b%b/%h want 100/0",
               ird4, ov4, bsy4, p4);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va [4] = '{8'h57, 8'h07, 8'h80, 8'h57};
    logic [7:0] vb [4] = '{8'h83, 8'h03, 8'h02, 8'h13};
    logic [7:0] ve [4] = '{8'hC1, 8'h09, 8'h1B, 8'hFE};
    logic [7:0] p;
    int lat;
    bit tmo;
    for (int i = 0; i < 4; i++) begin
      op8(0, va[i], vb[i], p, lat, tmo);
      total++;
      if (tmo || p !== ve[i] || lat != 8) begin
        bad++;
        $display("FAIL vec%0d: got prod=%h lat=%0d tmo=%0d want prod=%h lat=8",
                 i, p, lat, tmo, ve[i]);
      end
      @(negedge clk);
      total++;
      if (ird[0] !== 1'b1 || ov[0] !== 1'b0) begin
        bad++;
        $display("FAIL post_ack%0d: got rdy=%b vld=%b want 1 0",
                 i, ird[0], ov[0]);
      end
    end
  endtask

  task automatic test_early_done();
    logic [7:0] va [5] = '{8'hA5, 8'hA5, 8'hA5, 8'h57, 8'h07};
    logic [7:0] vb [5] = '{8'h00, 8'h00, 8'h01, 8'h83, 8'h03};
    logic [7:0] ve [5] = '{8'h00, 8'h00, 8'hA5, 8'hC1, 8'h09};
    int         vs [5] = '{0, 1, 1, 1, 1};
    int         vl [5] = '{8, 1, 1, 8, 2};
    logic [7:0] p;
    int lat;
    bit tmo;
    for (int i = 0; i < 5; i++) begin
      op8(vs[i], va[i], vb[i], p, lat, tmo);
      total++;
      if (tmo || p !== ve[i] || lat != vl[i]) begin
        bad++;
        $display("FAIL early%0d: got prod=%h lat=%0d tmo=%0d want prod=%h lat=%0d",
                 i, p, lat, tmo, ve[i], vl[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit tmo;
    start8(0, 8'h57, 8'h13);
    wait8(0, lat, tmo);
    total++;
    if (tmo) begin
      bad++;
      $display("FAIL bp_done: got timeout want out_valid");
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      iv[0] = 1'b1; a8[0] = 8'h02; b8[0] = 8'h03;
      @(negedge clk);
      total++;
      if ({ov[0], ird[0], p8[0]} !== {2'b10, 8'hFE}) begin
        bad++;
        $display("FAIL bp_hold%0d: got vld/rdy/prod=%b%b/%h want 10/fe",
                 i, ov[0], ird[0], p8[0]);
      end
    end
    ack8(0);
    @(negedge clk);
    total++;
    if (ird[0] !== 1'b1 || ov[0] !== 1'b0 || bsy[0] !== 1'b0) begin
      bad++;
      $display("FAIL bp_idle: got rdy/vld/busy=%b%b%b want 100",
               ird[0], ov[0], bsy[0]);
    end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(negedge clk);
    total++;
    if (bsy[0] !== 1'b1) begin
      bad++;
      $display("FAIL bp_accept: got busy=%b want 1", bsy[0]);
    end
    wait8(0, lat, tmo);
    total++;
    if (tmo || p8[0] !== 8'h06 || lat != 8) begin
      bad++;
      $display("FAIL bp_next: got prod=%h lat=%0d tmo=%0d want 06 lat=8",
               p8[0], lat, tmo);
    end
    if (!tmo) ack8(0);
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] p;
    int lat;
    bit tmo;
    start8(0, 8'h57, 8'h83);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({ird[0], ov[0], bsy[0], p8[0]} !== {3'b100, 8'h00}) begin
      bad++;
      $display("FAIL mid_reset: got rdy/vld/busy/prod=%b%b%b/%h want 100/00",
               ird[0], ov[0], bsy[0], p8[0]);
    end
    repeat (10) @(negedge clk);
    total++;
    if (ov[0] !== 1'b0 || ird[0] !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_quiet: got vld=%b rdy=%b want 0 1",
               ov[0], ird[0]);
    end
    op8(0, 8'h02, 8'h02, p, lat, tmo);
    total++;
    if (tmo || p !== 8'h04 || lat != 8) begin
      bad++;
      $display("FAIL after_reset: got prod=%h lat=%0d tmo=%0d want 04 lat=8",
               p, lat, tmo);
    end
  endtask

  task automatic test_width4();
    logic [3:0] p;
    logic [3:0] x;
    logic [3:0] y;
    bit tmo;
    op4(4'h8, 4'h2, p, tmo);
    total++;
    if (tmo || p !== 4'h3) begin
      bad++;
      $display("FAIL w4_8x2: got %h tmo=%0d want 3", p, tmo);
    end
    op4(4'hF, 4'hF, p, tmo);
    total++;
    if (tmo || p !== 4'hA) begin
      bad++;
      $display("FAIL w4_FxF: got %h tmo=%0d want a", p, tmo);
    end
    for (int i = 0; i < 200; i++) begin
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      op4(x, y, p, tmo);
      total++;
      if (tmo || p !== ref4(x, y)) begin
        bad++;
        $display("FAIL w4_rand %h*%h: got %h tmo=%0d want %h",
                 x, y, p, tmo, ref4(x, y));
      end
    end
  endtask

  initial begin
    a8[0] = '0; b8[0] = '0;
    a8[1] = '0; b8[1] = '0;
    test_reset();
    test_vectors();
    test_early_done();
    test_backpressure();
    test_reset_mid_run();
    test_width4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
